// File: rtl/tdl_tdc_core_if.sv
// rtl/tdl_tdc_core_if.sv - timestamp valid/ready stream between the TDC core and its consumer
interface tdl_tdc_core_if #(
  parameter int TAPS     = 64,
  parameter int COARSE_W = 16
);
  localparam int FINE_W = $clog2(TAPS + 1);

  logic [COARSE_W+FINE_W-1:0] ts_data;
  logic                       ts_sat;
  logic                       ts_valid;
  logic                       ts_ready;

  modport master (output ts_data, output ts_sat, output ts_valid, input ts_ready);
  modport slave  (input ts_data, input ts_sat, input ts_valid, output ts_ready);
endinterface

// File: rtl/tdl_tdc_core.sv
// rtl/tdl_tdc_core.sv - carry-chain TDC back end: tap sync, popcount fine, coarse merge, stream output
module tdl_tdc_core #(
  parameter int TAPS     = 64,
  parameter int COARSE_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TAPS-1:0]   tdl_taps,
  input  logic              enable,
  input  logic              single_shot,
  input  logic              arm,
  input  logic              ovf_clr,
  output logic              ovf,
  output logic              armed,
  tdl_tdc_core_if.master    ts
);
  localparam int FINE_W = $clog2(TAPS + 1);

  typedef enum logic [1:0] {IDLE, WAIT_ZERO, ARMED} state_t;

  state_t                     state_q, state_d;
  logic [TAPS-1:0]            s1_q, s2_q;
  logic [COARSE_W-1:0]        coarse_q, c1_q, c2_q, c3_q;
  logic [FINE_W-1:0]          f3_q;
  logic                       ev3_q, ev3_d;
  logic [COARSE_W+FINE_W-1:0] data_q, data_d;
  logic                       sat_q, sat_d;
  logic                       valid_q, valid_d;
  logic                       ovf_q, ovf_d;
  logic [FINE_W-1:0]          pc;
  logic                       zero;

  // Bubble-tolerant fine count: every set tap counts, wherever it sits.
  function automatic logic [FINE_W-1:0] popcount(input logic [TAPS-1:0] v);
    logic [FINE_W-1:0] n;
    n = '0;
    for (int i = 0; i < TAPS; i++) n = n + FINE_W'(v[i]);
    return n;
  endfunction

  assign pc   = popcount(s2_q);
  assign zero = (pc == '0);

  // Two-stage synchroniser for the asynchronous taps, coarse count travelling alongside.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= '0;
      s2_q     <= '0;
      coarse_q <= '0;
      c1_q     <= '0;
      c2_q     <= '0;
      c3_q     <= '0;
      f3_q     <= '0;
    end else begin
      s1_q     <= tdl_taps;
      s2_q     <= s1_q;
      coarse_q <= coarse_q + 1'b1;
      c1_q     <= coarse_q;
      c2_q     <= c1_q;
      c3_q     <= c2_q;
      f3_q     <= pc;
    end
  end

  // Capture FSM state and the event flag aligned with f3/c3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ev3_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ev3_q   <= ev3_d;
    end
  end

  // Leading-edge capture: a hit only counts once a zero code has been seen while armed.
  always_comb begin
    state_d = state_q;
    ev3_d   = 1'b0;
    case (state_q)
      IDLE:      if (!single_shot || arm) state_d = WAIT_ZERO;
      WAIT_ZERO: if (zero) state_d = ARMED;
      ARMED: begin
        if (!zero) begin
          ev3_d   = 1'b1;
          state_d = single_shot ? IDLE : WAIT_ZERO;
        end
      end
      default:   state_d = IDLE;
    endcase
    if (!enable) begin
      state_d = IDLE;
      ev3_d   = 1'b0;
    end
  end

  // Output holding register, handshake and sticky overflow (a drop beats a clear).
  always_comb begin
    data_d  = data_q;
    sat_d   = sat_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (valid_q && ts.ts_ready) valid_d = 1'b0;
    if (ovf_clr) ovf_d = 1'b0;
    if (ev3_q && enable) begin
      if (!valid_q || ts.ts_ready) begin
        data_d  = {c3_q, f3_q};
        sat_d   = (f3_q == FINE_W'(TAPS));
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // Output register bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      sat_q   <= sat_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ts.ts_data  = data_q;
  assign ts.ts_sat   = sat_q;
  assign ts.ts_valid = valid_q;
  assign ovf         = ovf_q;
  assign armed       = (state_q == ARMED);
endmodule

// File: tb/tb_tdl_tdc_core.sv
// tb/tb_tdl_tdc_core.sv - self-checking bench for tdl_tdc_core
module tb_tdl_tdc_core;
  localparam int TAPS = 64;
  localparam int CW   = 16;
  localparam int CWB  = 4;
  localparam int FW   = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, enable, single_shot, arm, ovf_clr, ovf, armed;
  logic [TAPS-1:0] tdl_taps;
  logic            rst_b_n, en_b, ss_b, arm_b, ovf_clr_b, ovf_b, armed_b;
  logic [TAPS-1:0] taps_b;

  tdl_tdc_core_if #(.TAPS(TAPS), .COARSE_W(CW))  ifa ();
  tdl_tdc_core_if #(.TAPS(TAPS), .COARSE_W(CWB)) ifb ();

  tdl_tdc_core #(.TAPS(TAPS), .COARSE_W(CW)) dut_a (
    .clk(clk), .rst_n(rst_n), .tdl_taps(tdl_taps), .enable(enable),
    .single_shot(single_shot), .arm(arm), .ovf_clr(ovf_clr), .ovf(ovf),
    .armed(armed), .ts(ifa.master));

  tdl_tdc_core #(.TAPS(TAPS), .COARSE_W(CWB)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .tdl_taps(taps_b), .enable(en_b),
    .single_shot(ss_b), .arm(arm_b), .ovf_clr(ovf_clr_b), .ovf(ovf_b),
    .armed(armed_b), .ts(ifb.master));

  int n_cmp = 0;
  int n_err = 0;

  // Reference coarse time: number of clock edges since reset release.
  int unsigned cyc, cyc_b;
  always @(posedge clk or negedge rst_n)   if (!rst_n)   cyc   <= 0; else cyc   <= cyc + 1;
  always @(posedge clk or negedge rst_b_n) if (!rst_b_n) cyc_b <= 0; else cyc_b <= cyc_b + 1;

  function automatic logic [FW-1:0] ref_fine(input logic [TAPS-1:0] v);
    return FW'($countones(v));
  endfunction

  function automatic logic [TAPS-1:0] rand_hit();
    logic [TAPS-1:0] v;
    int              len;
    len = $urandom_range(1, TAPS);
    v   = {TAPS{1'b1}} >> (TAPS - len);
    case ($urandom_range(0, 2))
      1: if (len >= 3) v[$urandom_range(0, len - 2)] = 1'b0;
      2: v = {$urandom, $urandom};
      default: ;
    endcase
    if (v == '0) v = 1;
    return v;
  endfunction

  task automatic drive(input logic [TAPS-1:0] v);
    @(negedge clk);
    tdl_taps = v;
  endtask

  // Drives one hit followed by three zero samples; returns the coarse time it was sampled at.
  task automatic hit(input logic [TAPS-1:0] v, output logic [CW-1:0] c);
    drive(v);
    c = cyc[CW-1:0];
    repeat (3) drive('0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; single_shot = 1'b0; arm = 1'b0; ovf_clr = 1'b0;
    tdl_taps = '0; ifa.ts_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (ifa.ts_data !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", ifa.ts_data); end
    n_cmp++; if (ifa.ts_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", ifa.ts_valid); end
    n_cmp++; if (ifa.ts_sat !== 1'b0) begin n_err++; $display("FAIL reset_sat: got %b want 0", ifa.ts_sat); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    n_cmp++; if (armed !== 1'b0) begin n_err++; $display("FAIL reset_armed: got %b want 0", armed); end
    rst_n = 1'b1;
    drive('0); drive('0);
    n_cmp++; if ({ifa.ts_valid, armed} !== 2'b00) begin n_err++; $display("FAIL post_reset_idle: got %b want 00", {ifa.ts_valid, armed}); end
  endtask

  task automatic test_basic();
    logic [CW-1:0] c;
    enable = 1'b1; single_shot = 1'b0; ifa.ts_ready = 1'b1;
    repeat (4) drive('0);
    drive(64'h0000_0000_000F_FFFF);
    c = cyc[CW-1:0];
    drive('0); drive('0); drive('0);
    n_cmp++; if (ifa.ts_valid !== 1'b0) begin n_err++; $display("FAIL basic_latency_early: got %b want 0", ifa.ts_valid); end
    drive('0);
    n_cmp++; if (ifa.ts_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", ifa.ts_valid); end
    n_cmp++; if (ifa.ts_data !== {c, 7'd20}) begin n_err++; $display("FAIL basic_data: got %h want %h", ifa.ts_data, {c, 7'd20}); end
    n_cmp++; if (ifa.ts_sat !== 1'b0) begin n_err++; $display("FAIL basic_sat: got %b want 0", ifa.ts_sat); end
  endtask

  task automatic test_bubble();
    logic [CW-1:0]    c;
    logic [CW+FW-1:0] got;
    logic             gsat;
    int               seen;
    drive('0); drive('0);
    hit(64'h0000_0000_0000_F7FF, c);
    drive('0);
    n_cmp++; if ({ifa.ts_valid, ifa.ts_data} !== {1'b1, c, 7'd15}) begin n_err++; $display("FAIL bubble_fine: got %b/%h want 1/%h", ifa.ts_valid, ifa.ts_data, {c, 7'd15}); end
    repeat (3) drive('0);
    seen = 0; got = '0; gsat = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(i < 5 ? {TAPS{1'b1}} : '0);
      if (i == 0) c = cyc[CW-1:0];
      if (ifa.ts_valid) begin seen++; got = ifa.ts_data; gsat = ifa.ts_sat; end
    end
    n_cmp++; if (seen !== 1) begin n_err++; $display("FAIL ones_event_count: got %0d want 1", seen); end
    n_cmp++; if ({gsat, got} !== {1'b1, c, 7'd64}) begin n_err++; $display("FAIL ones_sat_data: got %b/%h want 1/%h", gsat, got, {c, 7'd64}); end
  endtask

  task automatic test_backpressure();
    logic [TAPS-1:0]  v;
    logic [CW-1:0]    c;
    logic [CW+FW-1:0] e1;
    ifa.ts_ready = 1'b0;
    drive('0); drive('0);
    v = rand_hit(); hit(v, c); e1 = {c, ref_fine(v)};
    drive('0);
    n_cmp++; if ({ifa.ts_valid, ifa.ts_data, ovf} !== {1'b1, e1, 1'b0}) begin n_err++; $display("FAIL bp_first: got %b/%h/%b want 1/%h/0", ifa.ts_valid, ifa.ts_data, ovf, e1); end
    repeat (5) drive('0);
    v = rand_hit(); hit(v, c);
    drive('0);
    n_cmp++; if ({ifa.ts_valid, ifa.ts_data} !== {1'b1, e1}) begin n_err++; $display("FAIL bp_held: got %b/%h want 1/%h", ifa.ts_valid, ifa.ts_data, e1); end
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL bp_ovf_set: got %b want 1", ovf); end
    ovf_clr = 1'b1; drive('0); ovf_clr = 1'b0;
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL bp_ovf_clr: got %b want 0", ovf); end
    drive('0);
    v = rand_hit(); hit(v, c);
    ovf_clr = 1'b1; drive('0); ovf_clr = 1'b0;
    n_cmp++; if ({ovf, ifa.ts_data} !== {1'b1, e1}) begin n_err++; $display("FAIL bp_set_wins: got %b/%h want 1/%h", ovf, ifa.ts_data, e1); end
    ovf_clr = 1'b1; drive('0); ovf_clr = 1'b0;
    ifa.ts_ready = 1'b1; drive('0);
    n_cmp++; if ({ifa.ts_valid, ovf} !== 2'b00) begin n_err++; $display("FAIL bp_release: got %b want 00", {ifa.ts_valid, ovf}); end
  endtask

  task automatic test_back_to_back();
    logic [TAPS-1:0]  v;
    logic [CW-1:0]    c;
    logic [CW+FW-1:0] e;
    ifa.ts_ready = 1'b0;
    drive('0); drive('0);
    v = rand_hit(); hit(v, c); e = {c, ref_fine(v)};
    drive('0);
    n_cmp++; if ({ifa.ts_valid, ifa.ts_data} !== {1'b1, e}) begin n_err++; $display("FAIL b2b_first: got %b/%h want 1/%h", ifa.ts_valid, ifa.ts_data, e); end
    drive('0);
    v = rand_hit(); hit(v, c); e = {c, ref_fine(v)};
    ifa.ts_ready = 1'b1;
    drive('0);
    n_cmp++; if ({ifa.ts_valid, ifa.ts_data, ovf} !== {1'b1, e, 1'b0}) begin n_err++; $display("FAIL b2b_reload: got %b/%h/%b want 1/%h/0", ifa.ts_valid, ifa.ts_data, ovf, e); end
    drive('0);
    n_cmp++; if (ifa.ts_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b want 0", ifa.ts_valid); end
  endtask

  task automatic test_single_shot();
    logic [TAPS-1:0]  v;
    logic [CW-1:0]    c;
    logic [CW+FW-1:0] e;
    int               seen;
    enable = 1'b0; drive('0); drive('0);
    enable = 1'b1; single_shot = 1'b1;
    drive('0); drive('0);
    seen = 0;
    v = rand_hit(); hit(v, c);
    repeat (4) begin drive('0); if (ifa.ts_valid) seen++; end
    n_cmp++; if ({seen, armed} !== {32'd0, 1'b0}) begin n_err++; $display("FAIL ss_unarmed: got %0d/%b want 0/0", seen, armed); end
    arm = 1'b1; drive('0); arm = 1'b0;
    drive('0);
    n_cmp++; if (armed !== 1'b1) begin n_err++; $display("FAIL ss_armed: got %b want 1", armed); end
    v = rand_hit(); hit(v, c); e = {c, ref_fine(v)};
    drive('0);
    n_cmp++; if ({ifa.ts_valid, ifa.ts_data, armed} !== {1'b1, e, 1'b0}) begin n_err++; $display("FAIL ss_capture: got %b/%h/%b want 1/%h/0", ifa.ts_valid, ifa.ts_data, armed, e); end
    drive('0); drive('0);
    seen = 0;
    v = rand_hit(); hit(v, c);
    repeat (4) begin drive('0); if (ifa.ts_valid) seen++; end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL ss_second_ignored: got %0d events want 0", seen); end
  endtask

  // Random hits in continuous mode against a leading-edge model: a nonzero sample is
  // an event only when a zero sample has been seen since the previous event.
  task automatic test_random();
    logic [CW+FW-1:0] exp_q[$];
    logic [CW+FW-1:0] e;
    logic [TAPS-1:0]  v;
    bit               seen_zero;
    single_shot = 1'b0; ifa.ts_ready = 1'b1;
    repeat (4) drive('0);
    seen_zero = 1'b1;
    for (int i = 0; i < 306; i++) begin
      v = (i >= 300 || $urandom_range(0, 1) == 0) ? '0 : rand_hit();
      drive(v);
      if (ifa.ts_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL rand_spurious: got %h want no event", ifa.ts_data);
        end else begin
          e = exp_q.pop_front();
          if ({ifa.ts_sat, ifa.ts_data} !== {(e[FW-1:0] == 7'd64), e}) begin
            n_err++; $display("FAIL rand_event: got %b/%h want %b/%h", ifa.ts_sat, ifa.ts_data, (e[FW-1:0] == 7'd64), e);
          end
        end
      end
      if (v == '0) seen_zero = 1'b1;
      else if (seen_zero) begin exp_q.push_back({cyc[CW-1:0], ref_fine(v)}); seen_zero = 1'b0; end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rand_missing: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    logic [TAPS-1:0] p1, p2;
    @(negedge clk); rst_b_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); taps_b = '0;
      if (k >= 4 && cyc_b[3:0] == 4'd15) break;
    end
    p1 = rand_hit(); p2 = rand_hit();
    taps_b = p1;
    @(negedge clk); taps_b = '0;
    @(negedge clk); taps_b = p2;
    @(negedge clk); taps_b = '0;
    @(negedge clk);
    n_cmp++; if ({ifb.ts_valid, ifb.ts_data} !== {1'b1, 4'd15, ref_fine(p1)}) begin n_err++; $display("FAIL wrap_first: got %b/%h want 1/%h", ifb.ts_valid, ifb.ts_data, {4'd15, ref_fine(p1)}); end
    @(negedge clk);
    n_cmp++; if (ifb.ts_valid !== 1'b0) begin n_err++; $display("FAIL wrap_accept: got %b want 0", ifb.ts_valid); end
    @(negedge clk);
    n_cmp++; if ({ifb.ts_valid, ifb.ts_data} !== {1'b1, 4'd1, ref_fine(p2)}) begin n_err++; $display("FAIL wrap_second: got %b/%h want 1/%h", ifb.ts_valid, ifb.ts_data, {4'd1, ref_fine(p2)}); end
    #1 rst_b_n = 1'b0;
    #1;
    n_cmp++; if ({ifb.ts_valid, ifb.ts_data, ifb.ts_sat, ovf_b, armed_b} !== '0) begin n_err++; $display("FAIL wrap_async_reset: got %b/%h/%b/%b/%b want all 0", ifb.ts_valid, ifb.ts_data, ifb.ts_sat, ovf_b, armed_b); end
  endtask

  initial begin
    rst_b_n = 1'b0; en_b = 1'b1; ss_b = 1'b0; arm_b = 1'b0; ovf_clr_b = 1'b0;
    taps_b = '0; ifb.ts_ready = 1'b1;
    test_reset();
    test_basic();
    test_bubble();
    test_backpressure();
    test_back_to_back();
    test_single_shot();
    test_random();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got time limit reached want finished run");
    $fatal(1);
  end
endmodule
